// File: rtl/clock_disp_pkg.sv
// Shared digit-field layout and 7-segment constants for the clock display path.
// Used by the digit-code interface, the scan driver and the segment decoder.
package clock_disp_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned DIGIT_W    = 6;
    localparam int unsigned CODE_W     = 4;
    localparam int unsigned BLINK_BIT  = 5;
    localparam int unsigned DOT_BIT    = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [CODE_W-1:0] CODE_DASH = 4'd10;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digit_frame_t;

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Digit-code interface between the clock user interface (master) and the
// display scan driver (slave), including the board-side pin outputs.
interface seg_scan_driver_if;
    import clock_disp_pkg::*;

    logic [NUM_DIGITS*DIGIT_W-1:0] digits;
    logic [7:0]                    an;
    logic [6:0]                    seg;
    logic                          dp;

    modport master (output digits, input an, input seg, input dp);
    modport slave  (input digits, output an, output seg, output dp);

endinterface

// File: rtl/seg_scan_driver_seg7_decode.sv
// Combinational 4-bit code to active-low 7-segment pattern decoder.
module seg7_decode
    import clock_disp_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [6:0]        seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:      seg = SEG_0;
            4'd1:      seg = SEG_1;
            4'd2:      seg = SEG_2;
            4'd3:      seg = SEG_3;
            4'd4:      seg = SEG_4;
            4'd5:      seg = SEG_5;
            4'd6:      seg = SEG_6;
            4'd7:      seg = SEG_7;
            4'd8:      seg = SEG_8;
            4'd9:      seg = SEG_9;
            CODE_DASH: seg = SEG_DASH;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit common-anode 7-segment scan driver with dead time.
// Per-digit blinking is built only when SEG_BLINK_EN is defined.
module seg_scan_driver
    import clock_disp_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 12500,
    parameter int unsigned DEAD_CYCLES  = 250,
    parameter int unsigned BLINK_CYCLES = 25000000
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_driver_if.slave disp
);

    localparam int unsigned       SLOT_W    = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] DEAD_LAST = SLOT_W'(DEAD_CYCLES - 1);

    scan_state_e         state_q, state_d;
    logic [SLOT_W-1:0]   slot_cnt;
    logic [IDX_W-1:0]    idx;
    digit_frame_t        frame_reg;
    logic [DIGIT_W-1:0]  cur_digit;
    logic [6:0]          dec_seg;
    logic                slot_wrap;
    logic                slot_start;
    logic                hide;
    logic [7:0]          an_d;
    logic [6:0]          seg_d;
    logic                dp_d;

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign slot_start = (slot_cnt == '0);
    assign cur_digit  = frame_reg[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt  <= '0;
            idx       <= '0;
            frame_reg <= '0;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap) begin
                idx <= idx + 1'b1;
            end
            if (slot_start && idx == '0) begin
                frame_reg <= disp.digits;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned        BLINK_W    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic               slot_phase;
    logic               phase_next;

    // Slot sampling uses the post-toggle phase so a coincident wrap is not lost.
    assign phase_next = (blink_cnt == BLINK_LAST) ? ~blink_phase : blink_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            slot_phase  <= 1'b1;
        end else begin
            blink_cnt   <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
            blink_phase <= phase_next;
            if (slot_start) begin
                slot_phase <= phase_next;
            end
        end
    end

    assign hide = cur_digit[BLINK_BIT] & ~slot_phase;
`else
    logic unused_blink;
    assign unused_blink = ^{cur_digit[BLINK_BIT], BLINK_CYCLES[0]};
    assign hide         = 1'b0;
`endif

    seg7_decode u_decode (
        .code (cur_digit[CODE_W-1:0]),
        .seg  (dec_seg)
    );

    // state_q tracks the DEAD/ON phase of the current slot_cnt value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_DEAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        an_d    = '1;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        if (slot_wrap) begin
            state_d = ST_DEAD;
        end else if (slot_cnt == DEAD_LAST) begin
            state_d = ST_ON;
        end
        if (state_q == ST_ON) begin
            an_d = ~(8'b1 << idx);
            if (!hide) begin
                seg_d = dec_seg;
                dp_d  = ~cur_digit[DOT_BIT];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp.an  <= '1;
            disp.seg <= SEG_BLANK;
            disp.dp  <= 1'b1;
        end else begin
            disp.an  <= an_d;
            disp.seg <= seg_d;
            disp.dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with a per-edge arithmetic model.
// Blink expectations follow SEG_BLINK_EN exactly as the DUT is built.
module tb_seg_scan_driver;

    localparam int DC    = 8;
    localparam int DEADC = 2;
    localparam int BC    = 40;
    localparam int FRAME = 8 * DC;

    logic clk = 1'b0;
    logic rst;

    seg_scan_driver_if disp_if ();

    seg_scan_driver #(
        .DIGIT_CYCLES (DC),
        .DEAD_CYCLES  (DEADC),
        .BLINK_CYCLES (BC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (disp_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int          e = -1;
    bit          model_valid = 1'b0;
    logic [47:0] snap = '0;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;

    function automatic logic [6:0] pat(input logic [3:0] c);
        logic [6:0] table_v [16];
        table_v = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        return table_v[c];
    endfunction

    // Blink phase after edge n: starts visible, toggles on edges BC-1, 2BC-1, ...
    function automatic bit phase_after(input int n);
        return (((n + 1) / BC) % 2) == 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h edge=%0d t=%0t", name, got, exp, e, $time);
        end
    endtask

    // Reference model: expected pin values after each rising edge.
    always @(posedge clk) begin
        int slot, pos;
        logic [5:0] d;
        bit vis;
        if (rst) begin
            e           = -1;
            model_valid = 1'b1;
            exp_an      = 8'hFF;
            exp_seg     = 7'h7F;
            exp_dp      = 1'b1;
        end else if (model_valid) begin
            e++;
            if (e % FRAME == 0) snap = disp_if.digits;
            slot = (e / DC) % 8;
            pos  = e % DC;
            if (pos < DEADC) begin
                exp_an  = 8'hFF;
                exp_seg = 7'h7F;
                exp_dp  = 1'b1;
            end else begin
                d   = snap[slot*6 +: 6];
                vis = 1'b1;
`ifdef SEG_BLINK_EN
                vis = !d[5] || phase_after(e - pos);
`endif
                exp_an  = ~(8'h01 << slot);
                exp_seg = vis ? pat(d[3:0]) : 7'h7F;
                exp_dp  = vis ? ~d[4] : 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("an",  32'(disp_if.an),  32'(exp_an));
            chk("seg", 32'(disp_if.seg), 32'(exp_seg));
            chk("dp",  32'(disp_if.dp),  32'(exp_dp));
            chk("one_anode", 32'($countones(~disp_if.an) <= 1), 32'd1);
        end
    end

    task automatic wait_edge(input int n);
        int guard = 0;
        while (!(model_valid && !rst && e >= n) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_edge", 32'(e), 32'(n));
    endtask

    task automatic lit(input string name, input int n, input logic [7:0] a,
                       input logic [6:0] s, input logic p);
        wait_edge(n);
        chk({name, "_an"},  32'(disp_if.an),  32'(a));
        chk({name, "_seg"}, 32'(disp_if.seg), 32'(s));
        chk({name, "_dp"},  32'(disp_if.dp),  32'(p));
    endtask

    task automatic set_digit(input int i, input logic [5:0] v);
        logic [47:0] tmp;
        tmp            = disp_if.digits;
        tmp[i*6 +: 6]  = v;
        disp_if.digits = tmp;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout edge=%0d", e);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] dec;
        rst            = 1'b1;
        disp_if.digits = 48'({$urandom(), $urandom()});
        repeat (3) @(negedge clk);
        chk("reset_an", 32'(disp_if.an), 32'hFF);

        for (int i = 0; i < 8; i++) begin
            dec[i*6 +: 6] = {1'b0, (i == 3), 4'(i)};
        end
        disp_if.digits = dec;
        rst = 1'b0;

        lit("slot0_dead1", 1,  8'hFF, 7'h7F, 1'b1);
        lit("slot0_on",    2,  8'hFE, 7'h40, 1'b1);
        lit("slot0_last",  7,  8'hFE, 7'h40, 1'b1);
        lit("slot1_dead",  8,  8'hFF, 7'h7F, 1'b1);
        lit("slot3_dot",   28, 8'hF7, 7'h30, 1'b0);
        lit("slot5",       44, 8'hDF, 7'h12, 1'b1);
        lit("slot7",       63, 8'h7F, 7'h78, 1'b1);

        wait_edge(70);
        set_digit(0, 6'h0A);
        set_digit(1, 6'h0D);
        lit("dash",  131, 8'hFE, 7'h3F, 1'b1);
        lit("blank", 139, 8'hFD, 7'h7F, 1'b1);

        wait_edge(140);
        set_digit(5, 6'h01);
        wait_edge(211);
        set_digit(5, 6'h09);
        lit("snap_old", 236, 8'hDF, 7'h79, 1'b1);
        lit("snap_new", 300, 8'hDF, 7'h10, 1'b1);

        wait_edge(302);
        set_digit(0, 6'h28);
        lit("blink_vis", 324, 8'hFE, 7'h00, 1'b1);
`ifdef SEG_BLINK_EN
        lit("blink_hid", 388, 8'hFE, 7'h7F, 1'b1);
`else
        lit("blink_off", 388, 8'hFE, 7'h00, 1'b1);
`endif
        lit("blink_other", 404, 8'hFB, 7'h24, 1'b1);

        wait_edge(447);
        for (int k = 0; k < 6 * FRAME; k++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) disp_if.digits = 48'({$urandom(), $urandom()});
        end

        for (int i = 0; i < 8; i++) begin
            dec[i*6 +: 6] = (i == 0) ? 6'h04 : 6'h0F;
        end
        disp_if.digits = dec;
        lit("pre_rst_slot4", 932, 8'hEF, 7'h7F, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_an",  32'(disp_if.an),  32'hFF);
        chk("midrst_seg", 32'(disp_if.seg), 32'h7F);
        chk("midrst_dp",  32'(disp_if.dp),  32'h1);
        @(negedge clk);
        rst = 1'b0;
        lit("restart_slot0", 2,  8'hFE, 7'h19, 1'b1);
        lit("restart_slot1", 11, 8'hFD, 7'h7F, 1'b1);
        wait_edge(70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
